// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester (fetch / data) arbiter onto one downstream
// memory bus, with at most one transaction outstanding.
// Simultaneous requests use fixed data priority by default. Define
// MEM_ARB_RR_EN to grant simultaneous requests round-robin instead.
//
// state | meaning
// IDLE  | no transaction; arbitrate and latch the winner's request
// ADDR  | bus_req high, waiting for bus_addr_ok
// DATA  | address accepted, waiting for bus_data_ok
module mem_bus_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [2:0]  i_size,
    input  logic [3:0]  i_strobe,
    input  logic [31:0] i_wdata,
    output logic        i_addr_ok,
    output logic        i_data_ok,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [2:0]  d_size,
    input  logic [3:0]  d_strobe,
    input  logic [31:0] d_wdata,
    output logic        d_addr_ok,
    output logic        d_data_ok,
    output logic [31:0] d_rdata,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [2:0]  bus_size,
    output logic [3:0]  bus_strobe,
    output logic [31:0] bus_wdata,
    input  logic        bus_addr_ok,
    input  logic        bus_data_ok,
    input  logic [31:0] bus_rdata,
    output logic        owner,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [3:0]  strobe_q, strobe_d;
    logic [31:0] wdata_q, wdata_d;
    logic        owner_q, owner_d;
    logic        grant_data;
    logic        in_addr;
    logic        in_data;

`ifdef MEM_ARB_RR_EN
    // rr_q = 1 means data is favoured on the next simultaneous request
    logic        rr_q, rr_d;

    assign grant_data = (d_req && i_req) ? rr_q : d_req;

    // Pointer flips to favour whichever requester was not just granted
    always_comb begin
        rr_d = rr_q;
        if (state_q == IDLE && (i_req || d_req)) begin
            rr_d = ~grant_data;
        end
    end

    // Pointer register; reset favours data
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_q <= 1'b1;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    assign grant_data = d_req;
`endif

    // Next-state and request-latch logic
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        strobe_d = strobe_q;
        wdata_d  = wdata_q;
        owner_d  = owner_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d  = ADDR;
                    owner_d  = grant_data;
                    addr_d   = grant_data ? d_addr   : i_addr;
                    size_d   = grant_data ? d_size   : i_size;
                    strobe_d = grant_data ? d_strobe : i_strobe;
                    wdata_d  = grant_data ? d_wdata  : i_wdata;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and latched request registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            strobe_q <= '0;
            wdata_q  <= '0;
            owner_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            strobe_q <= strobe_d;
            wdata_q  <= wdata_d;
            owner_q  <= owner_d;
        end
    end

    assign in_addr = (state_q == ADDR);
    assign in_data = (state_q == DATA);

    // Downstream bus only ever sees the latched copy of the request
    assign bus_req    = in_addr;
    assign bus_addr   = addr_q;
    assign bus_size   = size_q;
    assign bus_strobe = strobe_q;
    assign bus_wdata  = wdata_q;

    // Handshakes are forwarded only to the owner and only in the matching state
    assign d_addr_ok = in_addr &  owner_q & bus_addr_ok;
    assign i_addr_ok = in_addr & ~owner_q & bus_addr_ok;
    assign d_data_ok = in_data &  owner_q & bus_data_ok;
    assign i_data_ok = in_data & ~owner_q & bus_data_ok;
    assign d_rdata   = d_data_ok ? bus_rdata : '0;
    assign i_rdata   = i_data_ok ? bus_rdata : '0;

    assign owner = owner_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter. Inputs change 1 time unit after
// posedge; outputs are checked 1 time unit after that.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [31:0] i_addr = '0, d_addr = '0;
    logic [2:0]  i_size = '0, d_size = '0;
    logic [3:0]  i_strobe = '0, d_strobe = '0;
    logic [31:0] i_wdata = '0, d_wdata = '0;
    logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
    logic [31:0] i_rdata, d_rdata;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [2:0]  bus_size;
    logic [3:0]  bus_strobe;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        owner, busy;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_size(i_size), .i_strobe(i_strobe), .i_wdata(i_wdata),
        .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_size(d_size), .d_strobe(d_strobe), .d_wdata(d_wdata),
        .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_size(bus_size), .bus_strobe(bus_strobe),
        .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok),
        .bus_rdata(bus_rdata), .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        i_req = 0; d_req = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0;
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        d_req = 1; i_req = 1; d_addr = 32'h1234_5678; bus_addr_ok = 1; bus_data_ok = 1; bus_rdata = 32'hFFFF_FFFF;
        tick(); tick();
        n_cmp++; if ({busy, bus_req, owner, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok} !== 7'b0) begin n_err++; $display("FAIL rst_ctrl: got %b want 0000000", {busy, bus_req, owner, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok}); end
        n_cmp++; if ({i_rdata, d_rdata} !== 64'h0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", {i_rdata, d_rdata}); end
        n_cmp++; if ({bus_addr, bus_size, bus_strobe, bus_wdata} !== 71'h0) begin n_err++; $display("FAIL rst_bus: got %h want 0", {bus_addr, bus_size, bus_strobe, bus_wdata}); end
        d_req = 0; i_req = 0; bus_addr_ok = 0; bus_data_ok = 0; bus_rdata = '0; d_addr = '0;
        resetn = 1'b1;
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_read();
        d_req = 1; d_addr = 32'h8000_0010; d_size = 3'd2; d_strobe = 4'b0000; d_wdata = '0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_c0_busy: got %b want 0", busy); end
        tick();
        bus_addr_ok = 1; #1;
        n_cmp++; if ({bus_req, busy, owner, d_addr_ok, i_addr_ok} !== 5'b11110) begin n_err++; $display("FAIL rd_c1_ctrl: got %b want 11110", {bus_req, busy, owner, d_addr_ok, i_addr_ok}); end
        n_cmp++; if (bus_addr !== 32'h8000_0010 || bus_strobe !== 4'b0000) begin n_err++; $display("FAIL rd_c1_bus: got %h/%b want 80000010/0000", bus_addr, bus_strobe); end
        tick();
        d_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hDEAD_BEEF; #1;
        n_cmp++; if ({d_data_ok, i_data_ok, bus_req} !== 3'b100) begin n_err++; $display("FAIL rd_c2_ctrl: got %b want 100", {d_data_ok, i_data_ok, bus_req}); end
        n_cmp++; if (d_rdata !== 32'hDEAD_BEEF || i_rdata !== 32'h0) begin n_err++; $display("FAIL rd_c2_rdata: got %h/%h want deadbeef/0", d_rdata, i_rdata); end
        tick();
        bus_data_ok = 0; bus_rdata = '0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rd_c3_busy: got %b want 0", busy); end
    endtask

    task automatic test_contention();
        do_reset();
        i_req = 1; i_addr = 32'h1000_0000; i_strobe = 4'b0000;
        d_req = 1; d_addr = 32'h2000_0000; d_strobe = 4'b1111; d_wdata = 32'h1234_5678;
        tick();
        bus_addr_ok = 1; #1;
        n_cmp++; if ({owner, d_addr_ok, i_addr_ok} !== 3'b110) begin n_err++; $display("FAIL ct_first_grant: got %b want 110", {owner, d_addr_ok, i_addr_ok}); end
        n_cmp++; if (bus_addr !== 32'h2000_0000 || bus_wdata !== 32'h1234_5678) begin n_err++; $display("FAIL ct_first_bus: got %h/%h want 20000000/12345678", bus_addr, bus_wdata); end
        tick();
        d_req = 0; d_strobe = 0; bus_addr_ok = 0; bus_data_ok = 1; #1;
        n_cmp++; if ({d_data_ok, i_data_ok} !== 2'b10) begin n_err++; $display("FAIL ct_first_data: got %b want 10", {d_data_ok, i_data_ok}); end
        tick();
        bus_data_ok = 0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ct_gap_busy: got %b want 0", busy); end
        tick();
        bus_addr_ok = 1; #1;
        n_cmp++; if ({owner, i_addr_ok, d_addr_ok} !== 3'b010 || bus_addr !== 32'h1000_0000) begin n_err++; $display("FAIL ct_second_grant: got %b/%h want 010/10000000", {owner, i_addr_ok, d_addr_ok}, bus_addr); end
        tick();
        i_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'hCAFE_F00D; #1;
        n_cmp++; if ({i_data_ok, d_data_ok} !== 2'b10 || i_rdata !== 32'hCAFE_F00D || d_rdata !== 32'h0) begin n_err++; $display("FAIL ct_second_data: got %b/%h/%h want 10/cafef00d/0", {i_data_ok, d_data_ok}, i_rdata, d_rdata); end
        tick();
        bus_data_ok = 0; bus_rdata = '0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ct_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_owner;
`ifdef MEM_ARB_RR_EN
        exp_owner = 4'b0101;
`else
        exp_owner = 4'b1111;
`endif
        do_reset();
        i_req = 1; d_req = 1; i_addr = 32'h0000_1000; d_addr = 32'h0000_2000;
        for (int k = 0; k < 4; k++) begin
            tick();
            bus_addr_ok = 1; #1;
            n_cmp++; if (owner !== exp_owner[k] || busy !== 1'b1) begin n_err++; $display("FAIL b2b_owner[%0d]: got %b/%b want %b/1", k, owner, busy, exp_owner[k]); end
            tick();
            bus_addr_ok = 0; bus_data_ok = 1; #1;
            n_cmp++; if ({d_data_ok, i_data_ok} !== {exp_owner[k], ~exp_owner[k]}) begin n_err++; $display("FAIL b2b_data[%0d]: got %b want %b", k, {d_data_ok, i_data_ok}, {exp_owner[k], ~exp_owner[k]}); end
            tick();
            bus_data_ok = 0;
        end
        i_req = 0; d_req = 0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_end_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure_store();
        d_req = 1; d_addr = 32'h8000_0100; d_size = 3'd0; d_strobe = 4'b0100; d_wdata = 32'h00AB_0000;
        tick();
        d_addr = 32'hFFFF_FFFC; d_size = 3'd2; d_strobe = 4'b1111; d_wdata = 32'h1111_1111; i_req = 1; i_addr = 32'h4444_0000;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_cmp++; if ({bus_addr, bus_size, bus_strobe, bus_wdata} !== {32'h8000_0100, 3'd0, 4'b0100, 32'h00AB_0000}) begin n_err++; $display("FAIL bp_hold[%0d]: got %h/%h/%b/%h want 80000100/0/0100/00ab0000", k, bus_addr, bus_size, bus_strobe, bus_wdata); end
            n_cmp++; if ({bus_req, d_addr_ok, i_addr_ok} !== 3'b100) begin n_err++; $display("FAIL bp_wait[%0d]: got %b want 100", k, {bus_req, d_addr_ok, i_addr_ok}); end
            tick();
        end
        bus_addr_ok = 1; #1;
        n_cmp++; if (d_addr_ok !== 1'b1 || bus_strobe !== 4'b0100 || bus_wdata !== 32'h00AB_0000) begin n_err++; $display("FAIL bp_accept: got %b/%b/%h want 1/0100/00ab0000", d_addr_ok, bus_strobe, bus_wdata); end
        tick();
        d_req = 0; bus_addr_ok = 0; bus_data_ok = 1; #1;
        n_cmp++; if ({d_data_ok, i_data_ok} !== 2'b10) begin n_err++; $display("FAIL bp_data: got %b want 10", {d_data_ok, i_data_ok}); end
        tick();
        bus_data_ok = 0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_gap_busy: got %b want 0", busy); end
        // the waiting fetch request must now be served, not lost
        tick();
        bus_addr_ok = 1; #1;
        n_cmp++; if ({owner, i_addr_ok} !== 2'b01 || bus_addr !== 32'h4444_0000) begin n_err++; $display("FAIL bp_waiter_grant: got %b/%h want 01/44440000", {owner, i_addr_ok}, bus_addr); end
        tick();
        i_req = 0; bus_addr_ok = 0; bus_data_ok = 1; #1;
        n_cmp++; if (i_data_ok !== 1'b1) begin n_err++; $display("FAIL bp_waiter_data: got %b want 1", i_data_ok); end
        tick();
        bus_data_ok = 0;
    endtask

    task automatic test_stray();
        bus_data_ok = 1; bus_addr_ok = 1; bus_rdata = 32'hDEAD_BEEF; #1;
        n_cmp++; if ({d_data_ok, i_data_ok, d_addr_ok, i_addr_ok} !== 4'b0 || d_rdata !== 32'h0 || i_rdata !== 32'h0) begin n_err++; $display("FAIL st_idle: got %b/%h/%h want 0000/0/0", {d_data_ok, i_data_ok, d_addr_ok, i_addr_ok}, d_rdata, i_rdata); end
        tick();
        bus_data_ok = 0; bus_addr_ok = 0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL st_idle_busy: got %b want 0", busy); end
        d_req = 1; d_addr = 32'h0000_0004; d_strobe = 4'b0000;
        tick();
        bus_data_ok = 1; #1;
        n_cmp++; if ({d_data_ok, d_addr_ok} !== 2'b00 || d_rdata !== 32'h0) begin n_err++; $display("FAIL st_addr: got %b/%h want 00/0", {d_data_ok, d_addr_ok}, d_rdata); end
        tick();
        bus_data_ok = 0; #1;
        n_cmp++; if ({bus_req, busy} !== 2'b11) begin n_err++; $display("FAIL st_addr_stay: got %b want 11", {bus_req, busy}); end
        bus_addr_ok = 1;
        tick();
        d_req = 0; bus_addr_ok = 0; bus_data_ok = 1; #1;
        n_cmp++; if (d_data_ok !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL st_data: got %b/%h want 1/deadbeef", d_data_ok, d_rdata); end
        tick();
        bus_data_ok = 0; bus_rdata = '0;
    endtask

    task automatic test_reset_mid();
        d_req = 1; d_addr = 32'h3000_0000; d_strobe = 4'b0011; d_wdata = 32'h0000_5555;
        tick();
        bus_addr_ok = 1;
        tick();
        d_req = 0; bus_addr_ok = 0; #1;
        n_cmp++; if ({busy, bus_req, owner} !== 3'b101) begin n_err++; $display("FAIL rm_in_data: got %b want 101", {busy, bus_req, owner}); end
        resetn = 0; #1;
        n_cmp++; if ({busy, bus_req, owner, d_addr_ok, d_data_ok, i_addr_ok, i_data_ok} !== 7'b0 || {bus_addr, bus_strobe, bus_wdata} !== 68'h0) begin n_err++; $display("FAIL rm_reset_out: got %b/%h want 0/0", {busy, bus_req, owner, d_addr_ok, d_data_ok, i_addr_ok, i_data_ok}, {bus_addr, bus_strobe, bus_wdata}); end
        tick();
        resetn = 1; bus_data_ok = 1; bus_rdata = 32'hBAD0_BAD0; #1;
        n_cmp++; if ({d_data_ok, i_data_ok, busy} !== 3'b0 || d_rdata !== 32'h0) begin n_err++; $display("FAIL rm_stale_data: got %b/%h want 000/0", {d_data_ok, i_data_ok, busy}, d_rdata); end
        tick();
        bus_data_ok = 0; bus_rdata = '0;
        d_req = 1; d_addr = 32'h5000_0000; d_strobe = 4'b0000;
        tick();
        bus_addr_ok = 1; #1;
        n_cmp++; if (d_addr_ok !== 1'b1 || bus_addr !== 32'h5000_0000) begin n_err++; $display("FAIL rm_next_addr: got %b/%h want 1/50000000", d_addr_ok, bus_addr); end
        tick();
        d_req = 0; bus_addr_ok = 0; bus_data_ok = 1; bus_rdata = 32'h0BAD_F00D; #1;
        n_cmp++; if (d_data_ok !== 1'b1 || d_rdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL rm_next_data: got %b/%h want 1/0badf00d", d_data_ok, d_rdata); end
        tick();
        bus_data_ok = 0; bus_rdata = '0; #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rm_end_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_back_to_back();
        test_backpressure_store();
        test_stray();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows (clock and reset first):
- clk  in  1  sole clock; all state updates on posedge.
- resetn  in  1  asynchronous reset, active-low.
- i_req / d_req  in  1  fetch / data request, held until matching x_addr_ok.
- i_addr / d_addr  in  32  byte address.
- i_size / d_size  in  3  msize_t encoding (MSIZE1/2/4).
- i_strobe / d_strobe  in  4  byte write enables; 0000 = read.
- i_wdata / d_wdata  in  32  store data, lane-aligned.
- i_addr_ok / d_addr_ok  out  1  request accepted.
- i_data_ok / d_data_ok  out  1  response valid.
- i_rdata / d_rdata  out  32  read data, valid with x_data_ok.
- bus_req  out  1  downstream request.
- bus_addr  out  32; bus_size  out  3; bus_strobe  out  4; bus_wdata  out  32.
- bus_addr_ok  in  1; bus_data_ok  in  1; bus_rdata  in  32.
- owner  out  1  0 = fetch, 1 = data; valid when busy.
- busy  out  1  transaction in flight.

Function
REQ-002 The FSM SHALL have exactly three states: IDLE, ADDR and DATA.
REQ-003 In IDLE, when any x_req is high, the block SHALL grant one requester, latch its addr/size/strobe/wdata, set owner, and go to ADDR on the next edge.
REQ-004 Without MEM_ARB_RR_EN, when both requests are high, data SHALL win (fixed priority).
REQ-005 In ADDR, bus_req SHALL be 1 and bus_* SHALL be driven only from the latched registers.
REQ-006 In ADDR, bus_addr_ok SHALL be passed combinationally to the owner's x_addr_ok; on bus_addr_ok the FSM SHALL go to DATA.
REQ-007 In DATA, bus_req SHALL be 0.
REQ-008 In DATA, bus_data_ok SHALL be passed combinationally to the owner's x_data_ok, with bus_rdata to its x_rdata; on bus_data_ok the FSM SHALL go to IDLE.
REQ-009 At most one transaction SHALL be outstanding.
REQ-010 The minimum request-to-data_ok latency SHALL be 2 cycles: req at cycle 0, addr_ok at cycle 1, data_ok at cycle 2. The next grant SHALL be no earlier than cycle 3.
REQ-011 The non-owner's x_addr_ok and x_data_ok SHALL be 0 at all times.
REQ-012 Both requesters' x_rdata SHALL be 0 except when their x_data_ok is high.
REQ-013 bus_addr_ok outside ADDR SHALL be ignored.
REQ-014 bus_data_ok outside DATA SHALL be ignored and SHALL not be forwarded.
REQ-015 A request arriving while busy SHALL wait; it SHALL not be lost or reordered with the owner's transaction.
REQ-016 busy SHALL be 1 in ADDR and DATA, and 0 in IDLE.
REQ-017 Latched fields SHALL be stable from grant to bus_addr_ok, independent of input changes.

Reset
REQ-018 On resetn low, at any time including mid-transaction, the state SHALL become IDLE.
REQ-019 On reset, all latched fields, owner, busy, bus_req and every x_addr_ok/x_data_ok/x_rdata SHALL be 0; the round-robin pointer SHALL be reset to favour data.
REQ-020 A bus_data_ok arriving after reset for a pre-reset transaction SHALL be discarded.
REQ-021 The first grant SHALL occur no earlier than the first posedge with resetn high.

Configuration
REQ-022 With macro MEM_ARB_RR_EN defined, simultaneous requests SHALL be granted round-robin: a 1-bit pointer favours the requester not granted last, updated at each grant.
REQ-023 With MEM_ARB_RR_EN undefined, fixed data priority SHALL apply and no pointer register SHALL exist.
REQ-024 Single-request behaviour SHALL be identical with or without MEM_ARB_RR_EN.

Verification
REQ-025 Single read: d_req, d_addr=0x8000_0010, strobe 0000; bus_addr_ok at c1, bus_data_ok+rdata 0xDEADBEEF at c2 -> bus_addr=0x8000_0010 at c1, d_addr_ok c1, d_data_ok with d_rdata=0xDEADBEEF at c2, busy 0 at c3.
REQ-026 Contention: i_req and d_req both asserted at c0 -> data served first, fetch granted immediately after data_ok. With MEM_ARB_RR_EN and repeated contention, grants alternate d,i,d,i.
REQ-027 Backpressure store: d_strobe 0100, wdata 0x00AB0000; bus_addr_ok delayed 3 cycles; inputs changed after c1 -> bus_* holds original values, d_addr_ok only when bus_addr_ok.
REQ-028 Stray handshakes: bus_data_ok pulsed in IDLE and ADDR -> no x_data_ok, state unchanged.
REQ-029 Reset mid-transaction: resetn low in DATA, then bus_data_ok after release -> all outputs 0, no x_data_ok, next d_req served normally.
